// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: matches the last PAT_LEN valid bits against a loadable pattern, with a saturating match counter.
// One-cycle registered detect pulse. No backpressure; in_valid gaps hold the partial match.
module seq_pattern_detector #(
  parameter int unsigned                PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0]         RST_PATTERN = PAT_LEN'(4'b1011),
  parameter logic                       RST_OVERLAP = 1'b1,
  parameter int unsigned                CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam int unsigned         FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d, hist_n;
  logic               ovl_q, ovl_d;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_n;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match;

  always_comb begin
    hist_n = {hist_q[PAT_LEN-2:0], in};
    fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    // A load in the same cycle discards the sample, so it can never match.
    match  = in_valid && !cfg_load && (fill_n == FILL_FULL) && (hist_n == pat_q);

    pat_d  = pat_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = 1'b0;
    cnt_d  = cnt_q;

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_n;
      fill_d = (match && !ovl_q) ? '0 : fill_n;
      out_d  = match;
    end

    if (count_clr) begin
      cnt_d = '0;
    end else if (match && !count_sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= RST_PATTERN;
      ovl_q  <= RST_OVERLAP;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign count_sat   = &cnt_q;

endmodule
